// File: rtl/result_tx_queue_if.sv
// Bundle of the push-side and UART-side signals of result_tx_queue.
// The optional sent_count wire exists only when RESULT_TXQ_SENT_COUNT_EN is defined.
interface result_tx_queue_if #(
  parameter int DEPTH = 16
);
  logic                     push;
  logic [15:0]              push_data;
  logic                     full;
  logic                     empty;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;
  logic                     tx_ready;
  logic                     send_data;
  logic [15:0]              tx_num;
`ifdef RESULT_TXQ_SENT_COUNT_EN
  logic [15:0]              sent_count;

  modport master (
    output push, push_data, tx_ready,
    input  full, empty, count, overflow, send_data, tx_num, sent_count
  );
  modport slave (
    input  push, push_data, tx_ready,
    output full, empty, count, overflow, send_data, tx_num, sent_count
  );
`else
  modport master (
    output push, push_data, tx_ready,
    input  full, empty, count, overflow, send_data, tx_num
  );
  modport slave (
    input  push, push_data, tx_ready,
    output full, empty, count, overflow, send_data, tx_num
  );
`endif
endinterface

// File: rtl/result_tx_queue.sv
// Circular FIFO of signed 16-bit results feeding a single-word UART transmitter.
// Optional launch counter on sent_count is enabled by defining RESULT_TXQ_SENT_COUNT_EN.
module result_tx_queue #(
  parameter int DEPTH = 16
) (
  input logic               clk,
  input logic               reset,
  result_tx_queue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, LAUNCH, HOLDOFF, DRAIN} state_t;

  state_t          state;
  state_t          next_state;
  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count_next;
  logic            pop;
  logic            push_ok;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.empty && bus.tx_ready) begin
          pop        = 1'b1;
          next_state = LAUNCH;
        end
      end
      LAUNCH:  next_state = HOLDOFF;
      HOLDOFF: next_state = DRAIN;   // tx_ready is stale here while the UART drops it
      DRAIN: begin
        if (bus.tx_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // A full queue still takes a push when the head leaves on the same edge.
  assign push_ok = bus.push && (!bus.full || pop);

  always_comb begin
    count_next = bus.count;
    case ({push_ok, pop})
      2'b10:   count_next = bus.count + CW'(1);
      2'b01:   count_next = bus.count - CW'(1);
      default: count_next = bus.count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      bus.count     <= '0;
      bus.empty     <= 1'b1;
      bus.full      <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.send_data <= 1'b0;
      bus.tx_num    <= '0;
    end else begin
      state         <= next_state;
      bus.count     <= count_next;
      bus.empty     <= (count_next == '0);
      bus.full      <= (count_next == FULL_LEVEL);
      bus.send_data <= pop;
      if (bus.push && !push_ok) bus.overflow <= 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr     <= rd_ptr + AW'(1);
        bus.tx_num <= mem[rd_ptr];
      end
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= bus.push_data;
  end

`ifdef RESULT_TXQ_SENT_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.sent_count <= '0;
    end else if (state == LAUNCH) begin
      bus.sent_count <= bus.sent_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_result_tx_queue.sv
// Randomized and directed bench for result_tx_queue against a queue-based reference model.
// Compiles with or without RESULT_TXQ_SENT_COUNT_EN.
module tb_result_tx_queue;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  result_tx_queue_if #(.DEPTH(DEPTH)) bus ();
  result_tx_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  // reference model: a queue plus a "UART lockout" window after each launch
  logic [15:0] q[$];
  bit          armed = 1'b1;
  int          since = 0;
  bit          pend_inc = 1'b0;
  logic [15:0] m_tx = '0;
  bit          m_send = 1'b0;
  bit          m_ovf = 1'b0;
  int          m_sent = 0;

  // behavioural UART and observation log
  int          busy = 0;
  int          uart_len = 20;
  logic [15:0] seen[$];
  logic [15:0] exp_words[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit will_pop(input bit rdy);
    return armed && (q.size() > 0) && rdy;
  endfunction

  task automatic model_edge(input bit p, input logic [15:0] d, input bit rdy, input bit rst);
    bit pop_now;
    bit push_now;
    if (rst) begin
      q.delete();
      armed = 1'b1; since = 0; pend_inc = 1'b0;
      m_tx = '0; m_send = 1'b0; m_ovf = 1'b0; m_sent = 0;
    end else begin
      if (pend_inc) m_sent = (m_sent + 1) % 65536;
      pend_inc = 1'b0;
      pop_now  = will_pop(rdy);
      push_now = p && (q.size() < DEPTH || pop_now);
      if (p && !push_now) m_ovf = 1'b1;
      if (pop_now) begin
        m_tx = q.pop_front();
        armed = 1'b0; since = 0; pend_inc = 1'b1;
      end else if (!armed) begin
        since++;
        if (since >= 3 && rdy) armed = 1'b1;
      end
      if (push_now) q.push_back(d);
      m_send = pop_now;
    end
  endtask

  task automatic step(input bit p, input logic [15:0] d, input bit rdy, input bit rst);
    bus.push = p; bus.push_data = d; bus.tx_ready = rdy; reset = rst;
    @(posedge clk);
    model_edge(p, d, rdy, rst);
    #1;
    check("send_data", 32'(bus.send_data), 32'(m_send));
    check("tx_num",    32'(bus.tx_num),    32'(m_tx));
    check("count",     32'(bus.count),     32'(q.size()));
    check("empty",     32'(bus.empty),     32'(q.size() == 0));
    check("full",      32'(bus.full),      32'(q.size() == DEPTH));
    check("overflow",  32'(bus.overflow),  32'(m_ovf));
`ifdef RESULT_TXQ_SENT_COUNT_EN
    check("sent_count", 32'(bus.sent_count), 32'(m_sent));
`endif
    if (busy > 0) busy--;
    if (bus.send_data === 1'b1) begin
      seen.push_back(bus.tx_num);
      busy = uart_len;
    end
  endtask

  task automatic ustep(input bit p, input logic [15:0] d, input bit rst);
    step(p, d, busy == 0, rst);
  endtask

  task automatic do_reset();
    busy = 0;
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    seen.delete();
    exp_words.delete();
  endtask

  task automatic compare_seen(input string tag);
    check({tag, "_len"}, 32'(seen.size()), 32'(exp_words.size()));
    for (int i = 0; i < exp_words.size() && i < seen.size(); i++)
      check(tag, 32'(seen[i]), 32'(exp_words[i]));
  endtask

  initial begin
    int lat;
    int extra;
    logic [15:0] w;

    bus.push = 1'b0; bus.push_data = '0; bus.tx_ready = 1'b1; reset = 1'b1;

    // reset then idle with tx_ready high
    do_reset();
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_count", 32'(bus.count), 32'd0);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("idle_no_send", 32'(seen.size()), 32'd0);

    // single word, 2-cycle latency
    uart_len = 20;
    lat = -1;
    step(1'b1, 16'h8001, 1'b1, 1'b0);
    if (bus.send_data === 1'b1) lat = 1;
    for (int k = 1; k < 40; k++) begin
      ustep(1'b0, '0, 1'b0);
      if (bus.send_data === 1'b1 && lat < 0) lat = k + 1;
    end
    check("latency", 32'(lat), 32'd2);
    check("hold_tx_num", 32'(bus.tx_num), 32'h8001);
    exp_words.push_back(16'h8001);
    compare_seen("single");

    // three back-to-back words, UART busy 20 cycles per launch
    do_reset();
    exp_words = '{16'h0001, 16'hFFFF, 16'h1234};
    foreach (exp_words[i]) ustep(1'b1, exp_words[i], 1'b0);
    for (int i = 0; i < 90; i++) ustep(1'b0, '0, 1'b0);
    compare_seen("burst3");
`ifdef RESULT_TXQ_SENT_COUNT_EN
    check("sent_count3", 32'(bus.sent_count), 32'd3);
`endif

    // fill with tx_ready low, then overflow
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      w = 16'(16'hA000 + i);
      exp_words.push_back(w);
      step(1'b1, w, 1'b0, 1'b0);
    end
    check("fill_full", 32'(bus.full), 32'd1);
    check("fill_count", 32'(bus.count), 32'(DEPTH));
    step(1'b1, 16'hDEAD, 1'b0, 1'b0);
    check("ovf_set", 32'(bus.overflow), 32'd1);
    check("ovf_count", 32'(bus.count), 32'(DEPTH));
    uart_len = 2;
    for (int i = 0; i < 150; i++) ustep(1'b0, '0, 1'b0);
    compare_seen("drain16");

    // push while full in the pop cycle; 32 words through wrapping pointers
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      w = 16'(16'h5000 + i);
      exp_words.push_back(w);
      step(1'b1, w, 1'b0, 1'b0);
    end
    extra = 0;
    for (int i = 0; i < 400; i++) begin
      if (extra < DEPTH && will_pop(busy == 0)) begin
        w = 16'(16'h6000 + extra);
        exp_words.push_back(w);
        ustep(1'b1, w, 1'b0);
        if (extra == 0) begin
          check("fullpop_count", 32'(bus.count), 32'(DEPTH));
          check("fullpop_ovf", 32'(bus.overflow), 32'd0);
        end
        extra++;
      end else begin
        ustep(1'b0, '0, 1'b0);
      end
    end
    compare_seen("wrap32");

    // reset during HOLDOFF with 5 words queued
    do_reset();
    uart_len = 20;
    for (int i = 0; i < 6; i++) step(1'b1, 16'(16'h0700 + i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("pre_launch", 32'(bus.send_data), 32'd1);
    step(1'b0, '0, 1'b0, 1'b0);
    check("holdoff_count", 32'(bus.count), 32'd5);
    step(1'b0, '0, 1'b0, 1'b1);
    check("midrst_count", 32'(bus.count), 32'd0);
    check("midrst_empty", 32'(bus.empty), 32'd1);
    check("midrst_send", 32'(bus.send_data), 32'd0);
    busy = 0;
    seen.delete();
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("midrst_quiet", 32'(seen.size()), 32'd0);
    exp_words = '{16'h7FFF, 16'h8000};
    foreach (exp_words[i]) ustep(1'b1, exp_words[i], 1'b0);
    for (int i = 0; i < 60; i++) ustep(1'b0, '0, 1'b0);
    compare_seen("relaunch");

    // randomized traffic with a jittery UART and rare resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit p;
      bit rdy;
      bit rst;
      uart_len = int'($urandom_range(0, 6));
      p   = ($urandom % 2) == 0;
      rst = ($urandom % 500) == 0;
      rdy = (busy == 0) && (($urandom % 8) != 0);
      step(p, 16'($urandom), rdy, rst);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
